// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period and high-time capture with stuck-line timeout
module pwm_capture #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic        clk_50mhz,
   input  logic        rst_n,
   input  logic        en,
   input  logic        pwm_in,
   output logic [31:0] period_cnt,
   output logic [31:0] high_cnt,
   output logic        meas_valid,
   output logic        timeout,
   output logic        stuck_high
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEAS_HIGH = 2'd2,
      MEAS_LOW  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, s_q, s_d_q;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] high_tmp_q, high_tmp_d;
   logic [31:0] period_q, period_d;
   logic [31:0] high_q, high_d;
   logic        valid_q, valid_d;
   logic        timeout_q, timeout_d;
   logic        stuck_q, stuck_d;

   logic        rise, fall;
   logic        cnt_expired;
   logic [31:0] cnt_inc;

   assign rise = s_q & ~s_d_q;
   assign fall = ~s_q & s_d_q;

   // Counter saturates rather than wrapping so a stuck line can never alias a period.
   assign cnt_inc     = (cnt_q >= TIMEOUT_CYCLES) ? TIMEOUT_CYCLES : cnt_q + 32'd1;
   // Expiry fires on the cycle the counter would reach the limit.
   assign cnt_expired = (cnt_q >= TIMEOUT_CYCLES - 32'd1);

   assign period_cnt = period_q;
   assign high_cnt   = high_q;
   assign meas_valid = valid_q;
   assign timeout    = timeout_q;
   assign stuck_high = stuck_q;

   // Two-flop synchroniser plus one delay flop for edge detection.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         s_d_q   <= 1'b0;
      end else begin
         sync1_q <= pwm_in;
         s_q     <= sync1_q;
         s_d_q   <= s_q;
      end
   end

   // State, counter and result registers.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 32'd0;
         high_tmp_q <= 32'd0;
         period_q   <= 32'd0;
         high_q     <= 32'd0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         high_tmp_q <= high_tmp_d;
         period_q   <= period_d;
         high_q     <= high_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         stuck_q    <= stuck_d;
      end
   end

   // Next-state logic; a real edge takes priority over a coincident timeout.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_inc;
      high_tmp_d = high_tmp_q;
      period_d   = period_q;
      high_d     = high_q;
      valid_d    = 1'b0;
      timeout_d  = timeout_q;
      stuck_d    = stuck_q;

      if (!en) begin
         state_d    = IDLE;
         cnt_d      = 32'd0;
         high_tmp_d = 32'd0;
         period_d   = 32'd0;
         high_d     = 32'd0;
         timeout_d  = 1'b0;
         stuck_d    = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = WAIT_RISE;
         cnt_d   = 32'd0;
      end else if (state_q == WAIT_RISE && rise) begin
         // First rise only aligns us; the partial period before it is discarded.
         state_d = MEAS_HIGH;
         cnt_d   = 32'd1;
      end else if (state_q == MEAS_HIGH && fall) begin
         state_d    = MEAS_LOW;
         high_tmp_d = cnt_q;
      end else if (state_q == MEAS_LOW && rise) begin
         state_d   = MEAS_HIGH;
         period_d  = cnt_q;
         high_d    = high_tmp_q;
         valid_d   = 1'b1;
         timeout_d = 1'b0;
         stuck_d   = 1'b0;
         cnt_d     = 32'd1;
      end else if (cnt_expired) begin
         state_d   = WAIT_RISE;
         period_d  = 32'd0;
         high_d    = 32'd0;
         valid_d   = 1'b1;
         timeout_d = 1'b1;
         stuck_d   = s_q;
         cnt_d     = 32'd0;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
module tb_pwm_capture;

   localparam logic [31:0] TO = 32'd8000;

   logic        clk_50mhz = 1'b0;
   logic        rst_n     = 1'b0;
   logic        en        = 1'b0;
   logic        pwm_in    = 1'b0;
   logic [31:0] period_cnt, high_cnt;
   logic        meas_valid, timeout, stuck_high;

   pwm_capture #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_50mhz (clk_50mhz),
      .rst_n     (rst_n),
      .en        (en),
      .pwm_in    (pwm_in),
      .period_cnt(period_cnt),
      .high_cnt  (high_cnt),
      .meas_valid(meas_valid),
      .timeout   (timeout),
      .stuck_high(stuck_high)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   typedef struct {
      logic [31:0] period;
      logic [31:0] high;
      logic        to;
      logic        sh;
      int          gap;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   last_cyc = 0;
   bit   strict = 1'b1;

   bit          gen_on    = 1'b0;
   logic        gen_level = 1'b0;
   int unsigned arr_n = 99, ccr_n = 25;

   always @(posedge clk_50mhz) cyc++;

   // PWM generator: reload values are shadowed and taken only at period start.
   initial begin
      int unsigned gcnt, arr, ccr;
      gcnt = 0; arr = 0; ccr = 0;
      forever begin
         @(negedge clk_50mhz);
         if (gen_on) begin
            if (gcnt == 0) begin
               arr = arr_n;
               ccr = ccr_n;
            end
            pwm_in = (gcnt < ccr);
            gcnt   = (gcnt == arr) ? 0 : gcnt + 1;
         end else begin
            pwm_in = gen_level;
            gcnt   = 0;
         end
      end
   end

   // Monitor: every strobe pops one expectation.
   always @(negedge clk_50mhz) begin
      exp_t e;
      if (meas_valid) begin
         if (q.size() == 0) begin
            if (strict) begin
               checks++;
               fails++;
               $display("FAIL unexpected_strobe got period=%0d high=%0d to=%0d sh=%0d want none",
                        period_cnt, high_cnt, timeout, stuck_high);
            end
         end else begin
            e = q.pop_front();
            checks++;
            if (period_cnt !== e.period || high_cnt !== e.high ||
                timeout !== e.to || stuck_high !== e.sh) begin
               fails++;
               $display("FAIL meas got period=%0d high=%0d to=%0d sh=%0d want period=%0d high=%0d to=%0d sh=%0d",
                        period_cnt, high_cnt, timeout, stuck_high, e.period, e.high, e.to, e.sh);
            end
            if (e.gap != 0) begin
               checks++;
               if (cyc - last_cyc != e.gap) begin
                  fails++;
                  $display("FAIL strobe_gap got %0d want %0d", cyc - last_cyc, e.gap);
               end
            end
         end
         last_cyc = cyc;
      end
   end

   task automatic push(input logic [31:0] p, input logic [31:0] h,
                       input logic t, input logic s, input int g);
      exp_t e;
      e.period = p; e.high = h; e.to = t; e.sh = s; e.gap = g;
      q.push_back(e);
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge clk_50mhz);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain_%s got pending=%0d want 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (period_cnt !== 32'd0 || high_cnt !== 32'd0 || meas_valid !== 1'b0 ||
          timeout !== 1'b0 || stuck_high !== 1'b0) begin
         fails++;
         $display("FAIL %s got period=%0d high=%0d valid=%0d to=%0d sh=%0d want all 0",
                  name, period_cnt, high_cnt, meas_valid, timeout, stuck_high);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk_50mhz);
      check_zero("reset_state");
      rst_n = 1'b1;
      @(negedge clk_50mhz);
      check_zero("idle_after_reset");

      // 100/25 steady state
      en = 1'b1;
      arr_n = 99; ccr_n = 25;
      gen_on = 1'b1;
      push(100, 25, 0, 0, 0);
      push(100, 25, 0, 0, 100);
      push(100, 25, 0, 0, 100);
      wait_drain(1000, "basic");

      // 5000/2500, then 5000/1; the period in flight still reports as before
      arr_n = 4999; ccr_n = 2500;
      push(100, 25, 0, 0, 100);
      push(5000, 2500, 0, 0, 5000);
      push(5000, 2500, 0, 0, 5000);
      wait_drain(20000, "p5000");
      ccr_n = 1;
      push(5000, 2500, 0, 0, 5000);
      push(5000, 1, 0, 0, 5000);
      push(5000, 1, 0, 0, 5000);
      wait_drain(20000, "ccr1");

      // stuck low, repeated timeout, then recovery
      gen_level = 1'b0;
      gen_on    = 1'b0;
      push(0, 0, 1, 0, 0);
      push(0, 0, 1, 0, 8000);
      wait_drain(20000, "stuck_low");
      arr_n = 99; ccr_n = 25;
      gen_on = 1'b1;
      push(100, 25, 0, 0, 0);
      wait_drain(1000, "recover_low");

      // stuck high, repeated timeout, then recovery
      gen_level = 1'b1;
      gen_on    = 1'b0;
      push(0, 0, 1, 1, 0);
      push(0, 0, 1, 1, 8000);
      wait_drain(20000, "stuck_high");
      gen_on = 1'b1;
      push(100, 25, 0, 0, 0);
      push(100, 25, 0, 0, 100);
      wait_drain(1000, "recover_high");

      // enable dropped during the high phase
      repeat (5) @(negedge clk_50mhz);
      en = 1'b0;
      repeat (10) @(negedge clk_50mhz);
      check_zero("en_low");
      en = 1'b1;
      push(100, 25, 0, 0, 0);
      push(100, 25, 0, 0, 100);
      wait_drain(1000, "reenable");

      // asynchronous reset mid-period, checked between clock edges
      repeat (40) @(negedge clk_50mhz);
      #3 rst_n = 1'b0;
      #2 check_zero("async_reset");
      @(negedge clk_50mhz);
      rst_n = 1'b1;
      push(100, 25, 0, 0, 0);
      push(100, 25, 0, 0, 100);
      wait_drain(1000, "after_reset");

      // minimum measurable values
      arr_n = 1; ccr_n = 1;
      push(100, 25, 0, 0, 100);
      push(2, 1, 0, 0, 2);
      push(2, 1, 0, 0, 2);
      wait_drain(1000, "minimum");

      strict = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
